// File: rtl/unidade_controle_pkg.sv
// Shared constants for the multicycle control unit: opcodes, ALU operation
// codes (also used by the ALU), FSM state encoding and instruction classes.
package unidade_controle_pkg;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_ADDI = 6'h02;
  localparam logic [5:0] OP_SUB  = 6'h03;
  localparam logic [5:0] OP_SUBI = 6'h04;
  localparam logic [5:0] OP_MUL  = 6'h05;
  localparam logic [5:0] OP_DIV  = 6'h06;
  localparam logic [5:0] OP_NOT  = 6'h07;
  localparam logic [5:0] OP_AND  = 6'h08;
  localparam logic [5:0] OP_OR   = 6'h09;
  localparam logic [5:0] OP_XOR  = 6'h0A;
  localparam logic [5:0] OP_SLT  = 6'h0B;
  localparam logic [5:0] OP_SGT  = 6'h0C;
  localparam logic [5:0] OP_BEQ  = 6'h0D;
  localparam logic [5:0] OP_BNEQ = 6'h0E;
  localparam logic [5:0] OP_SR   = 6'h0F;
  localparam logic [5:0] OP_SL   = 6'h10;
  localparam logic [5:0] OP_LW   = 6'h11;
  localparam logic [5:0] OP_SW   = 6'h12;
  localparam logic [5:0] OP_J    = 6'h13;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;
  localparam logic [3:0] ALU_NOT  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SGT  = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;
  localparam logic [3:0] ALU_BNEQ = 4'b1011;
  localparam logic [3:0] ALU_SR   = 4'b1100;
  localparam logic [3:0] ALU_SL   = 4'b1101;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } estado_t;

  typedef enum logic [3:0] {
    CL_ALU_R, CL_ALU_I, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_JUMP, CL_NOP, CL_HALT, CL_ILLEGAL
  } classe_t;

endpackage

// File: rtl/unidade_controle_decodificador_alu.sv
// Opcode -> ALU operation and instruction class. MUL/DIV are only
// recognised when MULDIV_EN is defined; otherwise they decode as illegal.
module decodificador_alu
  import unidade_controle_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [3:0] aluop,
  output classe_t    classe
);

  always_comb begin
    aluop  = ALU_ADD;
    classe = CL_ILLEGAL;
    case (opcode)
      OP_NOP:  classe = CL_NOP;
      OP_ADD:  classe = CL_ALU_R;
      OP_ADDI: classe = CL_ALU_I;
      OP_SUB:  begin aluop = ALU_SUB;  classe = CL_ALU_R; end
      OP_SUBI: begin aluop = ALU_SUB;  classe = CL_ALU_I; end
`ifdef MULDIV_EN
      OP_MUL:  begin aluop = ALU_MUL;  classe = CL_ALU_R; end
      OP_DIV:  begin aluop = ALU_DIV;  classe = CL_ALU_R; end
`endif
      OP_NOT:  begin aluop = ALU_NOT;  classe = CL_ALU_R; end
      OP_AND:  begin aluop = ALU_AND;  classe = CL_ALU_R; end
      OP_OR:   begin aluop = ALU_OR;   classe = CL_ALU_R; end
      OP_XOR:  begin aluop = ALU_XOR;  classe = CL_ALU_R; end
      OP_SLT:  begin aluop = ALU_SLT;  classe = CL_ALU_R; end
      OP_SGT:  begin aluop = ALU_SGT;  classe = CL_ALU_R; end
      OP_BEQ:  begin aluop = ALU_BEQ;  classe = CL_BRANCH; end
      OP_BNEQ: begin aluop = ALU_BNEQ; classe = CL_BRANCH; end
      OP_SR:   begin aluop = ALU_SR;   classe = CL_ALU_R; end
      OP_SL:   begin aluop = ALU_SL;   classe = CL_ALU_R; end
      OP_LW:   classe = CL_LOAD;
      OP_SW:   classe = CL_STORE;
      OP_J:    classe = CL_JUMP;
      OP_HALT: classe = CL_HALT;
      default: classe = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional MUL/DIV decode (and HIWRITE) enabled by `define MULDIV_EN.
module unidade_controle
  import unidade_controle_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] OPCODE,
  input  logic       ZERO,
  input  logic       MEMREADY,
  output logic [3:0] ALUop,
  output logic       ALUSRC,
  output logic       PCWRITE,
  output logic [1:0] PCSRC,
  output logic       IRWRITE,
  output logic       MEMREAD,
  output logic       MEMWRITE,
  output logic       REGWRITE,
  output logic       HIWRITE,
  output logic       REGDST,
  output logic       MEMTOREG,
  output logic       ILLEGAL,
  output logic       HALTED
);

  estado_t    estado, prox;
  logic [5:0] op_q;
  logic [5:0] dec_op;
  logic [3:0] dec_aluop;
  classe_t    classe;

  // DECODE must classify the live opcode (ILLEGAL pulses there); later
  // states use the copy latched at the end of DECODE.
  assign dec_op = (estado == ST_DECODE) ? OPCODE : op_q;

  decodificador_alu u_dec (
    .opcode (dec_op),
    .aluop  (dec_aluop),
    .classe (classe)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      estado <= ST_FETCH;
      op_q   <= OP_NOP;
    end else begin
      estado <= prox;
      if (estado == ST_DECODE) op_q <= OPCODE;
    end
  end

  always_comb begin
    prox = estado;
    case (estado)
      ST_FETCH:  if (MEMREADY) prox = ST_DECODE;
      ST_DECODE: begin
        case (classe)
          CL_NOP, CL_ILLEGAL: prox = ST_FETCH;
          CL_HALT:            prox = ST_HALT;
          default:            prox = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (classe)
          CL_LOAD, CL_STORE: prox = ST_MEM;
          CL_ALU_R, CL_ALU_I: prox = ST_WB;
          default:           prox = ST_FETCH;
        endcase
      end
      ST_MEM:  if (MEMREADY) prox = (classe == CL_LOAD) ? ST_WB : ST_FETCH;
      ST_WB:   prox = ST_FETCH;
      ST_HALT: prox = ST_HALT;
      default: prox = ST_FETCH;
    endcase
  end

  // Everything is gated by RST so outputs drop the instant reset asserts.
  always_comb begin
    ALUop    = ALU_ADD;
    ALUSRC   = 1'b0;
    PCWRITE  = 1'b0;
    PCSRC    = 2'b00;
    IRWRITE  = 1'b0;
    MEMREAD  = 1'b0;
    MEMWRITE = 1'b0;
    REGWRITE = 1'b0;
    HIWRITE  = 1'b0;
    REGDST   = 1'b0;
    MEMTOREG = 1'b0;
    ILLEGAL  = 1'b0;
    HALTED   = 1'b0;
    if (!RST) begin
      case (estado)
        ST_FETCH: begin
          MEMREAD = 1'b1;
          IRWRITE = MEMREADY;
          PCWRITE = MEMREADY;
        end
        ST_DECODE: ILLEGAL = (classe == CL_ILLEGAL);
        ST_EXEC: begin
          ALUop  = dec_aluop;
          ALUSRC = (classe == CL_ALU_I) || (classe == CL_LOAD) || (classe == CL_STORE);
          if (classe == CL_BRANCH && ZERO) begin
            PCWRITE = 1'b1;
            PCSRC   = 2'b01;
          end
          if (classe == CL_JUMP) begin
            PCWRITE = 1'b1;
            PCSRC   = 2'b10;
          end
        end
        ST_MEM: begin
          MEMREAD  = (classe == CL_LOAD);
          MEMWRITE = (classe == CL_STORE);
        end
        ST_WB: begin
          REGWRITE = 1'b1;
          REGDST   = (classe == CL_ALU_R);
          MEMTOREG = (classe == CL_LOAD);
`ifdef MULDIV_EN
          HIWRITE  = (dec_aluop == ALU_DIV);
`endif
        end
        ST_HALT: HALTED = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
